// File: rtl/vermibus_arbiter.sv
// Two-master, one-slave Vermibus arbiter: registered round-robin grant held for a whole
// transaction, with a watchdog that force-completes transactions a dead slave never acknowledges.
module vermibus_arbiter #(
    parameter int          TIMEOUT      = 256,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_address,
    input  logic [3:0]  m0_wstrobe,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_address,
    input  logic [3:0]  m1_wstrobe,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_address,
    output logic [3:0]  s_wstrobe,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        owner,
    output logic        busy,
    output logic        timeout
);

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic          WDOG_EN  = (TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_reg;
    logic          owner_reg;
    logic          last_reg;
    logic [CW-1:0] count_reg;

    logic owner_valid;
    logic wd_fire;
    logic s_valid_w;
    logic done;

    always_comb begin
        owner_valid = owner_reg ? m1_valid : m0_valid;
        // An aborting owner (valid low) is never force-completed; it simply drops the grant.
        wd_fire     = WDOG_EN && (state_reg == BUSY) && owner_valid &&
                      (count_reg == CNT_LAST) && !s_ready;
        s_valid_w   = (state_reg == BUSY) && owner_valid && !wd_fire;
        done        = (s_valid_w && s_ready) || wd_fire;
    end

    assign s_valid   = s_valid_w;
    assign m0_ready  = done && !owner_reg;
    assign m1_ready  = done && owner_reg;
    assign s_address = owner_reg ? m1_address : m0_address;
    assign s_wstrobe = owner_reg ? m1_wstrobe : m0_wstrobe;
    assign s_wdata   = owner_reg ? m1_wdata   : m0_wdata;
    assign m0_rdata  = (wd_fire && !owner_reg) ? TIMEOUT_DATA : s_rdata;
    assign m1_rdata  = (wd_fire && owner_reg)  ? TIMEOUT_DATA : s_rdata;
    assign busy      = (state_reg == BUSY);
    assign owner     = owner_reg;
    assign timeout   = wd_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    count_reg <= '0;
                    if (m0_valid || m1_valid) begin
                        state_reg <= BUSY;
                        owner_reg <= (m0_valid && m1_valid) ? ~last_reg : m1_valid;
                    end
                end
                BUSY: begin
                    if (done) begin
                        last_reg  <= owner_reg;
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end else if (!owner_valid) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end else if (!s_ready && (count_reg != '1)) begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Bench for vermibus_arbiter: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a transaction-level model of the arbitration rules.
module tb_vermibus_arbiter;

    localparam int          TO   = 4;
    localparam logic [31:0] DEAD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_address = '0, m1_address = '0;
    logic [3:0]  m0_wstrobe = '0, m1_wstrobe = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic        s_ready = 1'b0;
    logic [31:0] s_address;
    logic [3:0]  s_wstrobe;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata = '0;
    logic        owner, busy, timeout;

    vermibus_arbiter #(.TIMEOUT(TO), .TIMEOUT_DATA(DEAD)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_address(m0_address),
        .m0_wstrobe(m0_wstrobe), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_address(m1_address),
        .m1_wstrobe(m1_wstrobe), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_address(s_address),
        .s_wstrobe(s_wstrobe), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .owner(owner), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: granted master (-1 = none), last master served, BUSY cycles spent waiting.
    int m_own = -1, m_last = 1, m_wait = 0;
    int n_own = -1, n_last = 1, n_wait = 0;
    logic e_r0 = 1'b0, e_r1 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic at_neg();
        logic        bz, ov, fire, sv, fin;
        logic [31:0] oaddr, owd;
        logic [3:0]  ows;
        @(negedge clk);
        if (!reset) begin
            m_own = -1; m_last = 1; m_wait = 0;
        end
        bz    = (m_own >= 0);
        ov    = (m_own == 1) ? m1_valid : m0_valid;
        fire  = bz && ov && (m_wait >= TO - 1) && !s_ready;
        sv    = bz && ov && !fire;
        fin   = (sv && s_ready) || fire;
        e_r0  = fin && (m_own == 0);
        e_r1  = fin && (m_own == 1);
        oaddr = (m_own == 1) ? m1_address : m0_address;
        ows   = (m_own == 1) ? m1_wstrobe : m0_wstrobe;
        owd   = (m_own == 1) ? m1_wdata   : m0_wdata;
        chk("busy", busy, bz);
        chk("s_valid", s_valid, sv);
        chk("m0_ready", m0_ready, e_r0);
        chk("m1_ready", m1_ready, e_r1);
        chk("timeout", timeout, fire);
        chk("m0_rdata", m0_rdata, (fire && m_own == 0) ? DEAD : s_rdata);
        chk("m1_rdata", m1_rdata, (fire && m_own == 1) ? DEAD : s_rdata);
        if (!reset) chk("owner_rst", owner, 0);
        if (bz) begin
            chk("owner", owner, m_own);
            chk("s_address", s_address, oaddr);
            chk("s_wstrobe", s_wstrobe, ows);
            chk("s_wdata", s_wdata, owd);
        end
        n_own = m_own; n_last = m_last; n_wait = m_wait;
        if (!reset) begin
            n_own = -1; n_last = 1; n_wait = 0;
        end else if (!bz) begin
            n_wait = 0;
            if (m0_valid && m1_valid) n_own = 1 - m_last;
            else if (m0_valid)        n_own = 0;
            else if (m1_valid)        n_own = 1;
            else                      n_own = -1;
        end else if (fin) begin
            n_last = m_own; n_own = -1; n_wait = 0;
        end else if (!ov) begin
            n_own = -1; n_wait = 0;
        end else if (!s_ready) begin
            n_wait = m_wait + 1;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        m_own = n_own; m_last = n_last; m_wait = n_wait;
        #1;
    endtask

    task automatic cyc();
        at_neg();
        adv();
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = '0;
        m0_address = '0; m0_wstrobe = '0; m0_wdata = '0;
        m1_address = '0; m1_wstrobe = '0; m1_wdata = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " s_valid"}, s_valid, 0);
        chk({tag, " m0_ready"}, m0_ready, 0);
        chk({tag, " m1_ready"}, m1_ready, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " owner"}, owner, 0);
        chk({tag, " timeout"}, timeout, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        #1;
        check_reset_outputs("reset");
        cyc();
        reset = 1;
    endtask

    initial begin
        #1;
        do_reset();

        // Single m0 read, slave answers on the third BUSY cycle.
        m0_valid = 1; m0_address = 32'h100;
        at_neg(); chk("rd c0 s_valid", s_valid, 0); adv();
        at_neg(); chk("rd c1 s_valid", s_valid, 1); chk("rd c1 s_address", s_address, 32'h100); adv();
        at_neg(); chk("rd c2 m0_ready", m0_ready, 0); adv();
        s_ready = 1; s_rdata = 32'h12345678;
        at_neg(); chk("rd c3 m0_ready", m0_ready, 1); chk("rd c3 m0_rdata", m0_rdata, 32'h12345678); adv();
        m0_valid = 0; s_ready = 0;
        at_neg(); chk("rd c4 busy", busy, 0); adv();

        // Tie right after reset: m0 first, then m1.
        do_reset();
        m0_valid = 1; m1_valid = 1; s_ready = 1;
        at_neg(); chk("tie c0 busy", busy, 0); adv();
        at_neg(); chk("tie c1 owner", owner, 0); chk("tie c1 m0_ready", m0_ready, 1); adv();
        m0_valid = 0;
        at_neg(); chk("tie c2 busy", busy, 0); adv();
        at_neg(); chk("tie c3 owner", owner, 1); chk("tie c3 m1_ready", m1_ready, 1); adv();
        m1_valid = 0; s_ready = 0;
        cyc();

        // Continuous contention with a one-cycle slave: grants alternate.
        do_reset();
        m0_valid = 1; m1_valid = 1;
        for (int i = 0; i < 8; i++) begin
            s_ready = 0;
            at_neg(); chk("rr idle busy", busy, 0); adv();
            at_neg(); chk("rr owner", owner, i % 2); chk("rr busy", busy, 1); adv();
            s_ready = 1;
            at_neg(); chk("rr ready", (i % 2) ? m1_ready : m0_ready, 1); adv();
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;

        // m1 write pass-through while m0 drives unrelated values.
        m1_valid = 1; m1_address = 32'h2004; m1_wstrobe = 4'b0011; m1_wdata = 32'hAABBCCDD;
        m0_address = 32'hFFFF0000; m0_wstrobe = 4'hF; m0_wdata = 32'h11111111;
        cyc();
        m0_valid = 1;
        at_neg();
        chk("wr owner", owner, 1); chk("wr s_valid", s_valid, 1);
        chk("wr s_address", s_address, 32'h2004); chk("wr s_wstrobe", s_wstrobe, 4'b0011);
        chk("wr s_wdata", s_wdata, 32'hAABBCCDD);
        adv();
        s_ready = 1;
        at_neg(); chk("wr m1_ready", m1_ready, 1); chk("wr m0_ready", m0_ready, 0); adv();
        m1_valid = 0; s_ready = 0;
        at_neg(); chk("wr idle busy", busy, 0); adv();
        m0_valid = 0;
        at_neg(); chk("abort busy", busy, 1); chk("abort s_valid", s_valid, 0); adv();
        at_neg(); chk("abort idle", busy, 0); adv();

        // Watchdog with a slave that never answers.
        do_reset();
        m0_valid = 1;
        cyc();
        for (int k = 1; k <= 4; k++) begin
            at_neg();
            chk("wd timeout", timeout, k == 4);
            chk("wd m0_ready", m0_ready, k == 4);
            chk("wd s_valid", s_valid, k != 4);
            if (k == 4) chk("wd m0_rdata", m0_rdata, DEAD);
            adv();
        end
        m0_valid = 0;
        at_neg(); chk("wd after busy", busy, 0); adv();

        // Reset asserted mid-transaction, then an m1 request.
        do_reset();
        m0_valid = 1;
        cyc();
        at_neg(); chk("mid busy", busy, 1); adv();
        reset = 0; m0_valid = 0;
        #1;
        check_reset_outputs("mid");
        cyc();
        reset = 1; m1_valid = 1;
        at_neg(); chk("post c0 busy", busy, 0); adv();
        at_neg(); chk("post c1 busy", busy, 1); chk("post c1 owner", owner, 1); adv();
        m1_valid = 0;
        cyc();

        // Randomized traffic with aborts, stalls, timeouts and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (!reset) reset = 1;
            else if ($urandom_range(0, 499) == 0) reset = 0;
            if (!m0_valid || e_r0) begin
                m0_address = $urandom; m0_wstrobe = 4'($urandom); m0_wdata = $urandom;
                m0_valid = ($urandom_range(0, 2) == 0);
            end else if ($urandom_range(0, 31) == 0) begin
                m0_valid = 0;
            end
            if (!m1_valid || e_r1) begin
                m1_address = $urandom; m1_wstrobe = 4'($urandom); m1_wdata = $urandom;
                m1_valid = ($urandom_range(0, 2) == 0);
            end else if ($urandom_range(0, 31) == 0) begin
                m1_valid = 0;
            end
            s_ready = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vermibus_arbiter.md
Name: vermibus_arbiter

Overview:
- Two-master, one-slave arbiter for the Vermibus valid/ready memory protocol.
- Lets the Vermicel core (m0) and a second bus master, such as the DMA or debug port (m1), share a single memory/peripheral slave.
- Arbitration is registered round-robin. The grant is locked for a whole transaction.
- A watchdog completes any transaction the slave never acknowledges, so a dead slave cannot hang the core.

Parameters:
- TIMEOUT, 256: maximum cycles in BUSY before forced completion. 0 disables the watchdog.
- TIMEOUT_DATA, 32'hDEADBEEF: read data returned to the owner on a forced completion.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset: asserted when 0, released synchronously to clk.
- m0_valid  in  1  m0 request.
- m0_ready  out  1  m0 transaction complete.
- m0_address  in  32  m0 byte address.
- m0_wstrobe  in  4  m0 byte write enables; 0 means read.
- m0_wdata  in  32  m0 write data.
- m0_rdata  out  32  m0 read data.
- m1_valid, m1_ready, m1_address, m1_wstrobe, m1_wdata, m1_rdata: same as the m0 ports, for m1.
- s_valid  out  1  slave request.
- s_ready  in  1  slave completion.
- s_address  out  32  slave address.
- s_wstrobe  out  4  slave byte enables.
- s_wdata  out  32  slave write data.
- s_rdata  in  32  slave read data.
- owner  out  1  index of the granted master; meaningful only while busy = 1.
- busy  out  1  a grant is active.
- timeout  out  1  one-cycle pulse on a forced completion.

Behaviour:
- State machine has two states:
  - IDLE: no grant active.
  - BUSY: a transaction is in progress for the granted master.
- Internal registers: state_reg, owner_reg, last_reg (last master served), count_reg.
- Reset, while reset = 0 (asynchronous):
  - state_reg = IDLE, owner_reg = 0, last_reg = 1 (so m0 wins the first tie), count_reg = 0.
  - Outputs: s_valid = 0, m0_ready = 0, m1_ready = 0, busy = 0, owner = 0, timeout = 0.
- IDLE:
  - s_valid = 0; both m*_ready = 0.
  - Only m0_valid high → owner_reg <= 0, go to BUSY.
  - Only m1_valid high → owner_reg <= 1, go to BUSY.
  - Both high → owner_reg <= ~last_reg, go to BUSY.
  - Neither high → stay in IDLE.
  - count_reg <= 0.
- BUSY:
  - s_valid = valid of the owner.
  - s_address, s_wstrobe, s_wdata are muxed combinationally from the owner's inputs.
  - Owner's m_ready = s_ready & s_valid; the non-owner's ready = 0.
  - Both m*_rdata = s_rdata, except on a forced completion (below).
  - Arbitration latency is exactly one cycle: a request seen in IDLE at edge N drives s_valid from cycle N+1.
- Normal completion (s_valid & s_ready) → last_reg <= owner_reg, go to IDLE. Back-to-back requests therefore incur one idle cycle.
- Abort: owner's valid drops in BUSY without s_ready → go to IDLE. last_reg and timeout are unchanged.
- Watchdog (TIMEOUT > 0):
  - count_reg increments each BUSY cycle where s_ready = 0.
  - When count_reg == TIMEOUT-1 and s_ready = 0:
    - s_valid = 0.
    - Owner's m_ready = 1 with m_rdata = TIMEOUT_DATA.
    - timeout = 1.
    - last_reg <= owner_reg; go to IDLE.
  - If s_ready = 1 in that same cycle, normal completion wins and timeout = 0.
- count_reg width is $clog2(TIMEOUT+1) and saturates; it never wraps.
- The non-owner's valid has no effect while BUSY. It is only arbitrated on the next IDLE cycle.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at their reset values. No completion is signalled to any master.

Test Plan:
- Single m0 read: m0_valid = 1 at cycle 0, addr 0x100, slave ready at cycle 3 with rdata 0x12345678 → s_valid 1 from cycle 1; m0_ready = 1 and m0_rdata = 0x12345678 at cycle 3; busy = 0 at cycle 4.
- Simultaneous requests right after reset → m0 granted first (owner = 0). After its completion, m1 is granted on the next grant cycle (owner = 1).
- Both masters request continuously for 8 transactions, 1-cycle slave → grants alternate 0,1,0,1…; each transaction takes 3 cycles (IDLE + 2 BUSY); m1 is never starved.
- Write pass-through: m1 writes wstrobe 4'b0011, wdata 0xAABBCCDD, address 0x2004 → s_* outputs match exactly while owner = 1, with no corruption from m0's inputs.
- Watchdog, TIMEOUT = 4: slave never ready → m0_ready = 1, m0_rdata = 0xDEADBEEF, timeout = 1 in the 4th BUSY cycle; next cycle IDLE.
- Reset driven low mid-BUSY, then released, then m1 request → all outputs 0 immediately on reset; after release, m1 is granted after one cycle.
